cu_seq: RTL
===========

// Module: cu_seq
// PURPOSE
//  Parametrised multi-cycle control unit for the decode stage. ADD/NOT/LDD/STD/PUSH/POP/OUT/IN/JMP and similar decode in one cycle.
//  CALL, RET and RETI are sequenced over several stack beats, as is interrupt entry, with a stall to fetch/decode.
//  It replaces the purely combinational decode. It lets the PC be wider than one stack word.
// PARAMETERS
//  OPW       4  opcode width; opcode values below are the low 4 bits, upper bits must be 0 or the instruction is treated as NOP
//  PC_BEATS  2  stack words per PC (1..4); CALL/RET/RETI/interrupt push/pop this many words
//  SAVE_FLG  1  1: interrupt entry pushes flags after PC, RETI pops flags after PC; 0: no flag beat
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        synchronous reset, active low
//  opcode     in   OPW      opcode of instruction in decode
//  valid      in   1        decode holds a real instruction
//  interrupt  in   1        external interrupt request, level
//  ALU_src, reg_write, MEMR, MEMW, MTR, Branch, Out, In, PushPop, PushPc, PopPc, Spop   out 1 each, control signals
//  flg_push   out  1        current beat stores flags word
//  flg_pop    out  1        current beat restores flags word
//  vec_load   out  1        load PC from interrupt vector this cycle
//  beat       out  2        index of current PC word (0 = least significant)
//  stall      out  1        hold PC and IF/ID register this cycle
//  flush      out  1        squash instruction in fetch (last beat of redirect)
//  int_ack    out  1        one-cycle pulse when interrupt entry begins
//  state      out  2        00 IDLE, 01 PUSH, 10 POP, 11 INT
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, beat=0, int_pend=0.
//  int_pend is set on any cycle with interrupt=1. It is cleared in the cycle int_ack pulses.
//  IDLE, int_pend=1: the current decode is not issued; all control=0, int_ack=1, stall=1, go INT, beat=0. The interrupt beats the opcode.
//  IDLE, valid=0 or unknown opcode: all control 0, no stall.
//  IDLE, single-cycle opcode: combinational decode, no stall, stay IDLE. Lines not listed below are 0.
//   0x1, 0x0: all 0.
//   0x2: reg_write.
//   0x3: Out.
//   0x4: In, reg_write.
//   0x5: ALU_src, reg_write.
//   0x6: MEMW, PushPop, Spop.
//   0x7: MEMR, MTR, reg_write, Spop.
//   0xB: MEMR, MTR, reg_write.
//   0xC: MEMW.
//   0x8: Branch.
//  CALL 0x9: go PUSH. Each beat drives MEMW, PushPop, PushPc and Spop, with beat 0..PC_BEATS-1.
//   Beats 0..PC_BEATS-2: stall=1. Last beat: Branch=1, flush=1, stall=0, return IDLE.
//  RET 0xA: go POP. Each beat drives MEMR, PopPc and Spop; stall=1 except on the last beat.
//   Last beat: flush=1, then IDLE.
//  RETI 0xE: POP as RET. With SAVE_FLG=1, one extra beat follows with MEMR, Spop and flg_pop; flush and stall release are on that beat.
//  INT: PC_BEATS push beats (MEMW, PushPc, PushPop, Spop). With SAVE_FLG=1, a flag beat follows (MEMW, PushPop, Spop, flg_push).
//   Then one vec_load beat, which gives flush=1, stall=0, IDLE. stall=1 on all INT beats before vec_load.
//  Beats consumed per op: CALL/RET = PC_BEATS. RETI = PC_BEATS+SAVE_FLG. Interrupt = 1 (ack) + PC_BEATS + SAVE_FLG + 1.
//  beat counts up from 0 and returns to 0 on every return to IDLE. PC_BEATS=1 gives single-beat CALL/RET with stall=0.
//  During non-IDLE states opcode, valid and interrupt are ignored, but interrupt still sets int_pend. It is taken on the first IDLE cycle.
//  rst_n=0 mid-sequence: the next cycle is IDLE with all outputs 0 and int_pend cleared. No partial beat is completed.
// TESTING
//  1. Reset, then opcode=0x2 valid=1 -> reg_write=1, stall=0, state=00 the same cycle.
//  2. PC_BEATS=2, CALL -> cycle0 PushPc, beat=0, stall=1. cycle1 PushPc, beat=1, Branch=1, flush=1, stall=0. Then IDLE.
//  3. PC_BEATS=2, SAVE_FLG=1, RETI -> 3 cycles MEMR+Spop; flg_pop and flush on cycle 3; stall=1, 1, 0.
//  4. interrupt pulse during a RET beat -> RET completes. Next cycle int_ack=1. Then 2 push, 1 flag, 1 vec_load with flush.
//  5. interrupt and valid CALL in the same IDLE cycle -> int_ack=1, no PushPc that cycle, CALL not issued.
//  6. rst_n=0 on beat 1 of a 3-beat INT -> next cycle all outputs 0, state=00, no vec_load ever issued.

Source files
------------

// File: rtl/cu_if.sv
// cu_if: decode-stage bundle between the instruction decoder and the control unit.
interface cu_if #(parameter int OPW = 4);
    logic [OPW-1:0] opcode;
    logic valid, interrupt;
    logic ALU_src, reg_write, MEMR, MEMW, MTR, Branch, Out, In, PushPop, PushPc, PopPc, Spop;
    logic flg_push, flg_pop, vec_load, stall, flush, int_ack;
    logic [1:0] beat, state;
    modport master (
        output opcode, valid, interrupt,
        input ALU_src, reg_write, MEMR, MEMW, MTR, Branch, Out, In, PushPop, PushPc, PopPc, Spop,
        input flg_push, flg_pop, vec_load, stall, flush, int_ack, beat, state
    );
    modport slave (
        input opcode, valid, interrupt,
        output ALU_src, reg_write, MEMR, MEMW, MTR, Branch, Out, In, PushPop, PushPc, PopPc, Spop,
        output flg_push, flg_pop, vec_load, stall, flush, int_ack, beat, state
    );
endinterface

// File: rtl/cu_seq.sv
// cu_seq: decode-stage control unit; single-cycle decode plus multi-beat CALL/RET/RETI/interrupt stack sequencing.
module cu_seq #(
    parameter int OPW      = 4,
    parameter int PC_BEATS = 2,
    parameter int SAVE_FLG = 1
) (
    input logic clk,
    input logic rst_n,
    cu_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, PUSH = 2'b01, POP = 2'b10, INT = 2'b11} st_t;
    typedef struct packed {
        logic alu_src, reg_write, memr, memw, mtr, branch, out, in, push_pop, push_pc, pop_pc, spop;
        logic flg_push, flg_pop, vec_load, stall, flush, int_ack;
        logic [1:0] beat, state;
    } ctl_t;
    localparam logic [2:0] NPC = 3'(PC_BEATS);
    localparam logic [2:0] LAST = 3'(PC_BEATS - 1);
    localparam bit FLG = SAVE_FLG != 0;
    st_t st, st_n;
    logic [2:0] cnt, cnt_n;
    logic reti, reti_n, int_pend, pend, op_ok, last, single;
    logic [3:0] op;
    ctl_t c;
    assign op = bus.opcode[3:0];
    assign op_ok = bus.valid && (bus.opcode >> 4) == '0;
    assign pend = int_pend | bus.interrupt;
    always_comb begin
        c = '0;
        c.state = st;
        st_n = st;
        cnt_n = cnt;
        reti_n = reti;
        last = 1'b0;
        single = 1'b0;
        case (st)
            IDLE: begin
                if (pend) begin
                    c.int_ack = 1'b1;
                    c.stall = 1'b1;
                    st_n = INT;
                    cnt_n = '0;
                end else if (op_ok) begin
                    case (op)
                        4'h2: c.reg_write = 1'b1;
                        4'h3: c.out = 1'b1;
                        4'h4: {c.in, c.reg_write} = 2'b11;
                        4'h5: {c.alu_src, c.reg_write} = 2'b11;
                        4'h6: {c.memw, c.push_pop, c.spop} = 3'b111;
                        4'h7: {c.memr, c.mtr, c.reg_write, c.spop} = 4'b1111;
                        4'h8: c.branch = 1'b1;
                        4'hB: {c.memr, c.mtr, c.reg_write} = 3'b111;
                        4'hC: c.memw = 1'b1;
                        4'h9: begin
                            {c.memw, c.push_pop, c.push_pc, c.spop} = 4'b1111;
                            single = PC_BEATS == 1;
                            {c.branch, c.flush, c.stall} = {single, single, !single};
                            st_n = single ? IDLE : PUSH;
                            cnt_n = single ? 3'd0 : 3'd1;
                        end
                        4'hA, 4'hE: begin
                            {c.memr, c.pop_pc, c.spop} = 3'b111;
                            reti_n = op == 4'hE;
                            single = PC_BEATS == 1 && !(op == 4'hE && FLG);
                            {c.flush, c.stall} = {single, !single};
                            st_n = single ? IDLE : POP;
                            cnt_n = single ? 3'd0 : 3'd1;
                        end
                        default: ;
                    endcase
                end
            end
            PUSH: begin
                {c.memw, c.push_pop, c.push_pc, c.spop} = 4'b1111;
                c.beat = cnt[1:0];
                last = cnt == LAST;
                c.branch = last;
            end
            POP: begin
                if (cnt < NPC) begin
                    {c.memr, c.pop_pc, c.spop} = 3'b111;
                    c.beat = cnt[1:0];
                    last = cnt == LAST && !(reti && FLG);
                end else begin
                    {c.memr, c.spop, c.flg_pop} = 3'b111;
                    last = 1'b1;
                end
            end
            INT: begin
                if (cnt < NPC) begin
                    {c.memw, c.push_pc, c.push_pop, c.spop} = 4'b1111;
                    c.beat = cnt[1:0];
                end else if (FLG && cnt == NPC) begin
                    {c.memw, c.push_pop, c.spop, c.flg_push} = 4'b1111;
                end else begin
                    c.vec_load = 1'b1;
                    last = 1'b1;
                end
            end
        endcase
        if (st != IDLE) begin
            c.flush = last;
            c.stall = !last;
            st_n = last ? IDLE : st;
            cnt_n = last ? 3'd0 : cnt + 3'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= IDLE;
            cnt <= '0;
            reti <= 1'b0;
            int_pend <= 1'b0;
        end else begin
            st <= st_n;
            cnt <= cnt_n;
            reti <= reti_n;
            int_pend <= c.int_ack ? 1'b0 : pend;
        end
    end
    // Outputs are forced low while reset is asserted so no partial beat leaks out.
    assign {bus.ALU_src, bus.reg_write, bus.MEMR, bus.MEMW, bus.MTR, bus.Branch, bus.Out, bus.In,
            bus.PushPop, bus.PushPc, bus.PopPc, bus.Spop, bus.flg_push, bus.flg_pop, bus.vec_load,
            bus.stall, bus.flush, bus.int_ack, bus.beat, bus.state} = rst_n ? c : '0;
endmodule
